// File: rtl/rlc_stream_decoder.sv
// rlc_stream_decoder: expands MSB-first (value, run) tokens into packed output words.
// Ports: clk, reset_n (async, active-low);
//   in_data/in_nbits/in_last/in_valid/in_ready: bitstream input handshake;
//   out/out_keep/out_last/out_valid/out_ready: packed symbol output handshake.
// Optional: define RLC_EOB_EN for end-of-block tokens (zero fill to a BLOCK_SYMS boundary).
module rlc_stream_decoder #(
   parameter int IN_W       = 32,
   parameter int OUT_W      = 32,
   parameter int VAL_W      = 4,
   parameter int RUN_W      = 3,
   parameter int BLOCK_SYMS = 64
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [IN_W-1:0]                   in_data,
   input  logic [$clog2(IN_W+1)-1:0]         in_nbits,
   input  logic                              in_last,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic [OUT_W-1:0]                  out,
   output logic [$clog2(OUT_W/VAL_W+1)-1:0]  out_keep,
   output logic                              out_last,
   output logic                              out_valid,
   input  logic                              out_ready
);

   localparam int TOK_W  = VAL_W + RUN_W;
   localparam int SYMS   = OUT_W / VAL_W;
   localparam int BUF_W  = 2 * IN_W;
   localparam int CNT_W  = $clog2(BUF_W + 1);
   localparam int KEEP_W = $clog2(SYMS + 1);

   if (IN_W < TOK_W || (OUT_W % VAL_W) != 0 || BLOCK_SYMS < 1 ||
       (BLOCK_SYMS & (BLOCK_SYMS - 1)) != 0) begin : g_bad_cfg
      $error("rlc_stream_decoder: illegal parameter set");
   end

   typedef enum logic [1:0] {IDLE, FETCH, EMIT, FLUSH} state_t;

   state_t state, state_nxt;

   logic [BUF_W-1:0]  bits_q;
   logic [BUF_W-1:0]  shifted;
   logic [BUF_W-1:0]  appended;
   logic [BUF_W-1:0]  bits_nxt;
   logic [CNT_W-1:0]  bitcnt;
   logic [CNT_W-1:0]  base;
   logic [CNT_W-1:0]  added;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              end_seen;
   logic              end_nxt;
   logic              pop;
   logic              accept;
   logic              have_tok;
   state_t            after_tok;

   logic [TOK_W-1:0]  tok;
   logic [VAL_W-1:0]  tok_val;
   logic [RUN_W-1:0]  tok_run;
   logic [VAL_W-1:0]  cur_val;
   logic [RUN_W-1:0]  run_cnt;
   logic              send_val;
   logic [VAL_W-1:0]  sym;
   logic              last_sym;

   logic [OUT_W-1:0]  pack;
   logic [OUT_W-1:0]  pack_shift;
   logic [OUT_W-1:0]  flush_word;
   logic [KEEP_W-1:0] pack_cnt;

   logic              adv;
   logic              load_tok;
   logic              sym_go;
   logic              flush_go;

`ifdef RLC_EOB_EN
   localparam int BLK_W = (BLOCK_SYMS > 1) ? $clog2(BLOCK_SYMS) : 1;
   logic [BLK_W-1:0]  blk_cnt;
   logic              eob;
   logic              tok_eob;
`endif

   // Buffer holds the oldest bits in its MSBs; a pop and an append
   // may land in the same cycle, the append going behind the survivors.
   assign pop      = (state == FETCH);
   assign accept   = in_valid && in_ready;
   assign base     = pop ? bitcnt - CNT_W'(TOK_W) : bitcnt;
   assign added    = in_last ? CNT_W'(in_nbits) : CNT_W'(IN_W);
   assign cnt_nxt  = accept ? base + added : base;
   assign shifted  = pop ? bits_q << TOK_W : bits_q;
   assign appended = {in_data, {IN_W{1'b0}}} >> base;
   assign bits_nxt = accept ? (shifted | appended) : shifted;
   assign end_nxt  = end_seen || (accept && in_last);
   assign have_tok = (cnt_nxt >= CNT_W'(TOK_W));

   assign after_tok = have_tok ? FETCH : (end_nxt ? FLUSH : IDLE);

   assign in_ready = reset_n && !end_seen &&
                     (bitcnt <= CNT_W'(BUF_W - IN_W));

   assign tok     = bits_q[BUF_W-1 -: TOK_W];
   assign tok_val = tok[TOK_W-1 -: VAL_W];
   assign tok_run = tok[RUN_W-1:0];

   assign adv        = !out_valid || out_ready;
   assign sym        = send_val ? cur_val : '0;
   assign pack_shift = (pack << VAL_W) | OUT_W'(sym);
   // Pending symbols sit right-aligned; flush moves them to the MSBs.
   assign flush_word = pack << (VAL_W * (SYMS - int'(pack_cnt)));

`ifdef RLC_EOB_EN
   assign tok_eob  = (tok_val == '0) && (&tok_run);
   assign last_sym = eob ? (blk_cnt == BLK_W'(BLOCK_SYMS - 1)) :
                     send_val ? (run_cnt == '0) :
                     (run_cnt == RUN_W'(1));
`else
   assign last_sym = send_val ? (run_cnt == '0) :
                     (run_cnt == RUN_W'(1));
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load_tok  = 1'b0;
      sym_go    = 1'b0;
      flush_go  = 1'b0;
      unique case (state)
         IDLE: begin
            if (have_tok)     state_nxt = FETCH;
            else if (end_nxt) state_nxt = FLUSH;
         end
         FETCH: begin
            load_tok  = 1'b1;
            state_nxt = EMIT;
`ifdef RLC_EOB_EN
            // End-of-block already on a boundary emits nothing.
            if (tok_eob && blk_cnt == '0) state_nxt = after_tok;
`endif
         end
         EMIT: begin
            if (adv) begin
               sym_go = 1'b1;
               if (last_sym) state_nxt = after_tok;
            end
         end
         FLUSH: begin
            if (adv) begin
               flush_go  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bits_q    <= '0;
         bitcnt    <= '0;
         end_seen  <= 1'b0;
         cur_val   <= '0;
         run_cnt   <= '0;
         send_val  <= 1'b0;
         pack      <= '0;
         pack_cnt  <= '0;
         out       <= '0;
         out_keep  <= '0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
`ifdef RLC_EOB_EN
         blk_cnt   <= '0;
         eob       <= 1'b0;
`endif
      end else begin
         bits_q   <= bits_nxt;
         bitcnt   <= cnt_nxt;
         end_seen <= end_nxt;
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (load_tok) begin
            cur_val  <= tok_val;
            run_cnt  <= tok_run;
`ifdef RLC_EOB_EN
            eob      <= tok_eob;
            send_val <= !tok_eob;
`else
            send_val <= 1'b1;
`endif
         end
         if (sym_go) begin
            if (send_val) send_val <= 1'b0;
            else          run_cnt  <= run_cnt - RUN_W'(1);
`ifdef RLC_EOB_EN
            blk_cnt <= blk_cnt + BLK_W'(1);
`endif
            if (pack_cnt == KEEP_W'(SYMS - 1)) begin
               out       <= pack_shift;
               out_keep  <= KEEP_W'(SYMS);
               out_last  <= 1'b0;
               out_valid <= 1'b1;
               pack      <= '0;
               pack_cnt  <= '0;
            end else begin
               pack     <= pack_shift;
               pack_cnt <= pack_cnt + KEEP_W'(1);
            end
         end
         if (flush_go) begin
            out       <= flush_word;
            out_keep  <= pack_cnt;
            out_last  <= 1'b1;
            out_valid <= 1'b1;
            pack      <= '0;
            pack_cnt  <= '0;
            bits_q    <= '0;
            bitcnt    <= '0;
            end_seen  <= 1'b0;
`ifdef RLC_EOB_EN
            blk_cnt   <= '0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_rlc_stream_decoder.sv
// tb_rlc_stream_decoder: table vectors, corner sequences and random streams
// for rlc_stream_decoder, checked against a queue-based token model.
module tb_rlc_stream_decoder;

   localparam int IN_W       = 32;
   localparam int VAL_W      = 4;
   localparam int RUN_W      = 3;
   localparam int TOK_W      = VAL_W + RUN_W;
   localparam int SYMS       = 8;
   localparam int BLOCK_SYMS = 64;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] in_data;
   logic [5:0]  in_nbits;
   logic        in_last;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out;
   logic [3:0]  out_keep;
   logic        out_last;
   logic        out_valid;
   logic        out_ready;

   rlc_stream_decoder dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_data   (in_data),
      .in_nbits  (in_nbits),
      .in_last   (in_last),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out       (out),
      .out_keep  (out_keep),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int          nbits;
      logic        last;
   } word_t;

   typedef struct {
      logic [31:0] data;
      int          keep;
      logic        last;
   } oword_t;

   typedef struct {
      logic [31:0] data;
      int          nbits;
      int          nw;
      logic [31:0] o0;
      int          k0;
      logic        l0;
      logic [31:0] o1;
      int          k1;
      logic        l1;
   } vec_t;

   int     n_chk  = 0;
   int     n_pass = 0;
   oword_t exp_q[$];
   vec_t   vecs[6];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, want %h", name, act, req);
   endtask

   // Reference: flatten the stream to bits, cut tokens, expand, regroup.
   function automatic void model(input word_t ws[$]);
      bit         bq[$];
      logic [3:0] syms[$];
      int         blk;
      int         v;
      int         r;
      int         k;
      logic [31:0] w;
      blk = 0;
      foreach (ws[i]) begin
         int n;
         n = ws[i].last ? ws[i].nbits : IN_W;
         for (int b = 0; b < n; b++) bq.push_back(ws[i].data[31-b]);
      end
      while (bq.size() >= TOK_W) begin
         v = 0;
         r = 0;
         for (int b = 0; b < VAL_W; b++) v = v * 2 + int'(bq.pop_front());
         for (int b = 0; b < RUN_W; b++) r = r * 2 + int'(bq.pop_front());
`ifdef RLC_EOB_EN
         if (v == 0 && r == (1 << RUN_W) - 1) begin
            while (blk != 0) begin
               syms.push_back(4'h0);
               blk = (blk + 1) % BLOCK_SYMS;
            end
            continue;
         end
`endif
         syms.push_back(4'(v));
         for (int j = 0; j < r; j++) syms.push_back(4'h0);
         blk = (blk + 1 + r) % BLOCK_SYMS;
      end
      while (syms.size() >= SYMS) begin
         w = '0;
         for (int j = 0; j < SYMS; j++) w = (w << 4) | 32'(syms.pop_front());
         exp_q.push_back('{w, SYMS, 1'b0});
      end
      k = syms.size();
      w = '0;
      for (int j = 0; j < k; j++) w = (w << 4) | 32'(syms.pop_front());
      w = (k == 0) ? 32'h0 : (w << (4 * (SYMS - k)));
      exp_q.push_back('{w, k, 1'b1});
   endfunction

   task automatic push(input word_t w);
      int t;
      t        = 0;
      in_data  = w.data;
      in_nbits = 6'(w.nbits);
      in_last  = w.last;
      in_valid = 1'b1;
      while (!in_ready && t < 5000) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_chk++;
         $display("FAIL push_timeout: in_ready=%b after %0d cycles, want 1", in_ready, t);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drive(input word_t ws[$], input bit gaps);
      foreach (ws[i]) begin
         push(ws[i]);
         if (gaps) repeat ($urandom_range(2)) @(negedge clk);
      end
   endtask

   task automatic collect(input int n, input int pct);
      int          got;
      int          t;
      logic        pv;
      logic        pr;
      logic [31:0] po;
      logic [3:0]  pk;
      logic        pl;
      oword_t      e;
      got = 0;
      t   = 0;
      pv  = 1'b0;
      pr  = 1'b0;
      po  = '0;
      pk  = '0;
      pl  = 1'b0;
      while (got < n && t < 20000) begin
         @(negedge clk);
         t++;
         if (pv && !pr)
            check("hold", {out_valid, out, out_keep, out_last}, {1'b1, po, pk, pl});
         out_ready = (int'($urandom_range(99)) < pct);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL extra_word: got %h, want none", out);
            end else begin
               e = exp_q.pop_front();
               check("out_data", out, e.data);
               check("out_keep", out_keep, e.keep);
               check("out_last", out_last, e.last);
            end
            got++;
         end
         pv = out_valid;
         pr = out_ready;
         po = out;
         pk = out_keep;
         pl = out_last;
      end
      if (got < n) begin
         n_chk++;
         $display("FAIL collect_timeout: got %0d words, want %0d", got, n);
         exp_q.delete();
      end
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int pct);
      exp_q.push_back('{v.o0, v.k0, v.l0});
      if (v.nw > 1) exp_q.push_back('{v.o1, v.k1, v.l1});
      fork
         push('{v.data, v.nbits, 1'b1});
         collect(v.nw, pct);
      join
   endtask

   initial begin
      word_t ws[$];
      int    nw;
      int    pct;
      int    n;
      int    t;
      int    nacc;
      word_t w;

      vecs[0] = '{32'hA463E000, 21, 2, 32'hA003F000, 8, 1'b0, 32'h00000000, 1, 1'b1};
      vecs[1] = '{32'h7E000000,  7, 2, 32'h70000000, 8, 1'b0, 32'h00000000, 0, 1'b1};
      vecs[2] = '{32'h50000000,  7, 1, 32'h50000000, 1, 1'b1, 32'h0, 0, 1'b0};
      vecs[3] = '{32'hFFFFFFFF,  5, 1, 32'h00000000, 0, 1'b1, 32'h0, 0, 1'b0};
      vecs[4] = '{32'h1224489F, 32, 2, 32'h10101010, 8, 1'b0, 32'h00000000, 0, 1'b1};
      vecs[5] = '{32'h27840000, 14, 1, 32'h2000C000, 6, 1'b1, 32'h0, 0, 1'b0};

      reset_n   = 1'b0;
      in_data   = '0;
      in_nbits  = '0;
      in_last   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out", out, 0);
      check("rst_keep", out_keep, 0);
      check("rst_last", out_last, 0);
      check("rst_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      reset_n = 1'b1;
      @(negedge clk);
      check("idle_in_ready", in_ready, 1);

      foreach (vecs[i]) run_vec(vecs[i], 100);

      // Output stalled: first word must sit unchanged, nothing lost.
      out_ready = 1'b0;
      exp_q.push_back('{vecs[0].o0, vecs[0].k0, vecs[0].l0});
      exp_q.push_back('{vecs[0].o1, vecs[0].k1, vecs[0].l1});
      push('{vecs[0].data, vecs[0].nbits, 1'b1});
      repeat (20) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", out_valid, 1);
         check("stall_data", out, 32'hA003F000);
         @(negedge clk);
      end
      collect(2, 100);

      // Token straddling two input words.
      exp_q.push_back('{32'h55555555, 8, 1'b0});
      exp_q.push_back('{32'h00000000, 0, 1'b1});
      fork
         begin
            push('{32'h50A14285, 32, 1'b0});
            push('{32'h0A142800, 24, 1'b1});
         end
         collect(2, 100);
      join

      // Fill the buffer under backpressure until in_ready drops.
      out_ready = 1'b0;
      nacc      = 0;
      in_data   = '0;
      in_last   = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (in_ready) nacc++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("full_in_ready", in_ready, 0);
      check("full_valid", out_valid, 1);
      check("full_keep", out_keep, 8);
      ws.delete();
      for (int i = 0; i < nacc; i++) ws.push_back('{32'h0, 32, 1'b0});
      ws.push_back('{32'h50000000, 7, 1'b1});
      model(ws);
      n = exp_q.size();
      fork
         push('{32'h50000000, 7, 1'b1});
         collect(n, 100);
      join

      // Reset while a token is mid-emission with a word pending.
      out_ready = 1'b0;
      push('{32'h7EFC0000, 14, 1'b1});
      t = 0;
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(negedge clk);
      check("pre_rst_valid", out_valid, 1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_out", out, 0);
      check("mid_rst_keep", out_keep, 0);
      check("mid_rst_last", out_last, 0);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_vec(vecs[0], 100);

      // Random streams with random gaps and random backpressure.
      for (int s = 0; s < 25; s++) begin
         ws.delete();
         nw  = $urandom_range(4, 1);
         pct = $urandom_range(100, 30);
         for (int i = 0; i < nw; i++) begin
            w.data  = $urandom;
            w.last  = (i == nw - 1);
            w.nbits = w.last ? int'($urandom_range(32, 1)) : 32;
            ws.push_back(w);
         end
         model(ws);
         n = exp_q.size();
         fork
            drive(ws, 1'b1);
            collect(n, pct);
         join
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
